// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion and synchronizer limits.
// Conversions work on a wide zero-extended word so any pointer width up to PTR_MAX_W can use them.
package fifo_pkg;

    localparam int SYNC_STAGES_MAX = 4;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int PTR_MAX_W       = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_wide_t;

    // Zero-extended upper bits leave the result unchanged, so callers cast in and truncate out.
    function automatic ptr_wide_t bin2gray(input ptr_wide_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_wide_t gray2bin(input ptr_wide_t gray);
        ptr_wide_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchronizer chain; also used for single-bit CDC.
module sync_chain #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [STAGES-1:0][WIDTH-1:0] stage;

    // NOTE: the chain is held in a packed array so a single '0 clears every stage;
    // an unpacked memory would need a reset loop and would not map to plain flops as cleanly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage <= '0;
        end else begin
            stage[0] <= i_d;
            for (int k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign o_q = stage[STAGES-1];

endmodule

// File: rtl/ptr_sync_multi.sv
// Gray pointer synchronizer with registered binary copy, per-cycle advance and change pulse.
// Optional sticky step check enabled by defining PTR_SYNC_STEP_CHECK_EN.
module ptr_sync_multi
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 3,
    parameter int SYNC_STAGES = 2,
    parameter int MAX_STEP    = 2 ** ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [ADDR_WIDTH:0]   i_ptr_gray,
    input  logic                  i_err_clr,
    output logic [ADDR_WIDTH:0]   o_sync_gray,
    output logic [ADDR_WIDTH:0]   o_sync_bin,
    output logic [ADDR_WIDTH:0]   o_delta,
    output logic                  o_changed,
    output logic                  o_step_err
);

    localparam int PW = ADDR_WIDTH + 1;

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("ptr_sync_multi: SYNC_STAGES=%0d outside %0d..%0d",
               SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end

    if (MAX_STEP > (2 ** PW) - 1) begin : g_bad_step
        $error("ptr_sync_multi: MAX_STEP=%0d exceeds %0d", MAX_STEP, (2 ** PW) - 1);
    end

    logic [PW-1:0] sync_gray;
    logic [PW-1:0] sync_bin;
    logic [PW-1:0] bin_prev;
    logic [PW-1:0] delta;

    sync_chain #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync_chain (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_ptr_gray),
        .o_q     (sync_gray)
    );

    // NOTE: sequential state uses non-blocking assignments so bin_prev picks up the
    // value sync_bin held before this edge, giving a clean one-cycle history.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_bin <= '0;
            bin_prev <= '0;
        end else begin
            sync_bin <= PW'(gray2bin(ptr_wide_t'(sync_gray)));
            bin_prev <= sync_bin;
        end
    end

    // Modulo subtraction handles the pointer wrap without special casing.
    assign delta = sync_bin - bin_prev;

    assign o_sync_gray = sync_gray;
    assign o_sync_bin  = sync_bin;
    assign o_delta     = delta;
    assign o_changed   = |delta;

`ifdef PTR_SYNC_STEP_CHECK_EN
    localparam logic [PW-1:0] STEP_LIMIT = PW'(MAX_STEP);

    logic step_err;

    // Backward movement wraps to a large delta, so one compare covers both cases.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            step_err <= 1'b0;
        end else if (delta > STEP_LIMIT) begin
            step_err <= 1'b1;
        end else if (i_err_clr) begin
            step_err <= 1'b0;
        end
    end

    assign o_step_err = step_err;
`else
    logic unused_err_clr;

    assign unused_err_clr = i_err_clr;
    assign o_step_err     = 1'b0;
`endif

endmodule

// File: tb/tb_ptr_sync_multi.sv
// Directed bench for ptr_sync_multi: a 2-stage and a 3-stage instance share one stimulus.
module tb_ptr_sync_multi;
    import fifo_pkg::*;

`ifdef PTR_SYNC_STEP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ptr_gray;
    logic       err_clr;

    logic [3:0] g2, b2, d2;
    logic       c2, e2;
    logic [3:0] g3, b3, d3;
    logic       c3, e3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ptr_sync_multi #(.ADDR_WIDTH(3), .SYNC_STAGES(2)) dut2 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ptr_gray  (ptr_gray),
        .i_err_clr   (err_clr),
        .o_sync_gray (g2),
        .o_sync_bin  (b2),
        .o_delta     (d2),
        .o_changed   (c2),
        .o_step_err  (e2)
    );

    ptr_sync_multi #(.ADDR_WIDTH(3), .SYNC_STAGES(3)) dut3 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_ptr_gray  (ptr_gray),
        .i_err_clr   (err_clr),
        .o_sync_gray (g3),
        .o_sync_bin  (b3),
        .o_delta     (d3),
        .o_changed   (c3),
        .o_step_err  (e3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [3:0] gray4(input int unsigned b);
        ptr_wide_t w;
        w = bin2gray(ptr_wide_t'(b));
        return w[3:0];
    endfunction

    initial begin
        // Reset with a nonzero input present
        rst_n    = 1'b0;
        ptr_gray = 4'b1010;
        err_clr  = 1'b0;
        tick(3);
        check("rst_gray",    32'(g2), 0);
        check("rst_bin",     32'(b2), 0);
        check("rst_delta",   32'(d2), 0);
        check("rst_changed", 32'(c2), 0);
        check("rst_err",     32'(e2), 0);
        check("rst_gray3",   32'(g3), 0);
        rst_n = 1'b1;
        tick();
        check("rel_gray",    32'(g2), 0);
        check("rel_bin",     32'(b2), 0);
        check("rel_changed", 32'(c2), 0);

        // Clean restart from a zero input
        rst_n    = 1'b0;
        ptr_gray = 4'b0000;
        tick();
        rst_n = 1'b1;
        tick(5);
        check("idle_bin", 32'(b2), 0);

        // Latency 0 -> 1
        ptr_gray = 4'b0001;
        tick();
        check("lat_e1_gray2", 32'(g2), 0);
        tick();
        check("lat_e2_gray2", 32'(g2), 1);
        check("lat_e2_gray3", 32'(g3), 0);
        check("lat_e2_chg2",  32'(c2), 0);
        tick();
        check("lat_e3_bin2",  32'(b2), 1);
        check("lat_e3_chg2",  32'(c2), 1);
        check("lat_e3_dlt2",  32'(d2), 1);
        check("lat_e3_gray3", 32'(g3), 1);
        check("lat_e3_chg3",  32'(c3), 0);
        tick();
        check("lat_e4_chg2",  32'(c2), 0);
        check("lat_e4_bin3",  32'(b3), 1);
        check("lat_e4_chg3",  32'(c3), 1);
        tick();
        check("lat_e5_chg3",  32'(c3), 0);

        // Wrap 15 -> 0; clear whatever the 1 -> 15 jump flagged first
        ptr_gray = gray4(15);
        tick(6);
        check("wrap_hold_bin", 32'(b2), 15);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("wrap_pre_err", 32'(e2), 0);
        ptr_gray = gray4(0);
        tick(3);
        check("wrap_delta", 32'(d2), 1);
        check("wrap_chg",   32'(c2), 1);
        check("wrap_bin",   32'(b2), 0);
        tick();
        check("wrap_err",   32'(e2), 0);

        // Multi-step 2 -> 7
        ptr_gray = gray4(2);
        tick(5);
        ptr_gray = 4'b0100;
        tick(3);
        check("multi_delta", 32'(d2), 5);
        check("multi_chg",   32'(c2), 1);
        tick();
        check("multi_err",   32'(e2), 0);

        // Backward 7 -> 6
        ptr_gray = gray4(6);
        tick(3);
        check("back_delta", 32'(d2), 15);
        tick();
        check("back_err",   32'(e2), 32'(EXP_ERR));
        tick(10);
        check("back_hold2", 32'(e2), 32'(EXP_ERR));
        check("back_hold3", 32'(e3), 32'(EXP_ERR));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_err2", 32'(e2), 0);
        check("clr_err3", 32'(e3), 0);

        // Violation 6 -> 5 coincident with clear
        ptr_gray = gray4(5);
        tick(3);
        check("coin_delta", 32'(d2), 15);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("coin_err", 32'(e2), 32'(EXP_ERR));

        // Asynchronous reset mid-operation at bin 9
        ptr_gray = gray4(9);
        tick(6);
        check("pre_rst_bin", 32'(b2), 9);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_gray",  32'(g2), 0);
        check("arst_bin",   32'(b2), 0);
        check("arst_delta", 32'(d2), 0);
        check("arst_chg",   32'(c2), 0);
        check("arst_err",   32'(e2), 0);
        check("arst_bin3",  32'(b3), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        check("post_delta", 32'(d2), 9);
        check("post_chg",   32'(c2), 1);
        tick();
        check("post_delta0", 32'(d2), 0);
        check("post_chg0",   32'(c2), 0);
        check("post_err",    32'(e2), 32'(EXP_ERR));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
